// File: rtl/mccu_hs_if.sv
// rtl/mccu_hs_if.sv - decode, memory handshake and datapath control bundle for mccu_hs
interface mccu_hs_if;
   logic [5:0] op;
   logic [5:0] func;
   logic       z;
   logic       mem_ready;
   logic       mem_req;
   logic       wpc;
   logic       wir;
   logic       wmem;
   logic       wreg;
   logic       iord;
   logic       regrt;
   logic       m2reg;
   logic       shift;
   logic       alusrca;
   logic       jal;
   logic       sext;
   logic [3:0] aluc;
   logic [1:0] alusrcb;
   logic [2:0] pcsource;
   logic       wepc;
   logic [1:0] cause;
   logic [2:0] state;

   modport master (
      input  op, func, z, mem_ready,
      output mem_req, wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext,
             aluc, alusrcb, pcsource, wepc, cause, state
   );

   modport slave (
      output op, func, z, mem_ready,
      input  mem_req, wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext,
             aluc, alusrcb, pcsource, wepc, cause, state
   );
endinterface

// File: rtl/mccu_hs.sv
// rtl/mccu_hs.sv - multicycle control unit with memory wait states, watchdog and trap state
module mccu_hs #(
   parameter int TRAP_EN  = 1,
   parameter int WAIT_W   = 4,
   parameter int MAX_WAIT = 15
) (
   input logic       clock,
   input logic       resetn,
   mccu_hs_if.master bus
);
   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_TRAP = 3'b101
   } state_t;

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;
   localparam bit                TIMEOUT_EN = (TRAP_EN != 0) && (MAX_WAIT != 0);

   state_t            st;
   logic [WAIT_W-1:0] wait_cnt;
   logic [1:0]        cause_q;

   wire r_type = (bus.op == 6'b000000);
   wire i_add  = r_type & (bus.func == 6'b100000);
   wire i_sub  = r_type & (bus.func == 6'b100010);
   wire i_and  = r_type & (bus.func == 6'b100100);
   wire i_or   = r_type & (bus.func == 6'b100101);
   wire i_xor  = r_type & (bus.func == 6'b100110);
   wire i_sll  = r_type & (bus.func == 6'b000000);
   wire i_srl  = r_type & (bus.func == 6'b000010);
   wire i_sra  = r_type & (bus.func == 6'b000011);
   wire i_jr   = r_type & (bus.func == 6'b001000);
   wire i_addi = (bus.op == 6'b001000);
   wire i_andi = (bus.op == 6'b001100);
   wire i_ori  = (bus.op == 6'b001101);
   wire i_xori = (bus.op == 6'b001110);
   wire i_lw   = (bus.op == 6'b100011);
   wire i_sw   = (bus.op == 6'b101011);
   wire i_beq  = (bus.op == 6'b000100);
   wire i_bne  = (bus.op == 6'b000101);
   wire i_lui  = (bus.op == 6'b001111);
   wire i_j    = (bus.op == 6'b000010);
   wire i_jal  = (bus.op == 6'b000011);

   wire i_shift    = i_sll | i_srl | i_sra;
   wire i_zext_imm = i_andi | i_ori | i_xori;
   wire i_imm      = i_addi | i_zext_imm | i_lui;
   wire i_jump     = i_j | i_jal | i_jr;
   wire legal      = i_add | i_sub | i_and | i_or | i_xor | i_shift | i_jump | i_imm
                   | i_lw | i_sw | i_beq | i_bne;

   // Branches compare by subtraction; address calculation adds.
   wire [3:0] aluc_dec = {
      i_sra,
      i_sub | i_or | i_srl | i_sra | i_ori | i_lui | i_beq | i_bne,
      i_xor | i_sll | i_srl | i_sra | i_xori | i_lui,
      i_and | i_or | i_sll | i_srl | i_sra | i_andi | i_ori
   };

   wire wait_expired = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         st       <= S_IF;
         wait_cnt <= '0;
         cause_q  <= 2'b00;
      end else begin
         wait_cnt <= '0;
         case (st)
            S_IF, S_MEM: begin
               // A completing access always wins over an expiring watchdog.
               if (bus.mem_ready) begin
                  if (st == S_IF)
                     st <= S_ID;
                  else if (i_lw)
                     st <= S_WB;
                  else
                     st <= S_IF;
               end else if (wait_expired) begin
                  st      <= S_TRAP;
                  cause_q <= 2'b10;
               end else if (wait_cnt != WAIT_SAT) begin
                  wait_cnt <= wait_cnt + WAIT_ONE;
               end else begin
                  wait_cnt <= wait_cnt;
               end
            end
            S_ID: begin
               if (i_jump) begin
                  st <= S_IF;
               end else if (!legal) begin
                  if (TRAP_EN != 0) begin
                     st      <= S_TRAP;
                     cause_q <= 2'b01;
                  end else begin
                     st <= S_IF;
                  end
               end else begin
                  st <= S_EXE;
               end
            end
            S_EXE: begin
               if (i_beq | i_bne)
                  st <= S_IF;
               else if (i_lw | i_sw)
                  st <= S_MEM;
               else
                  st <= S_WB;
            end
            default: st <= S_IF;
         endcase
      end
   end

   always_comb begin
      bus.mem_req  = 1'b0;
      bus.wpc      = 1'b0;
      bus.wir      = 1'b0;
      bus.wmem     = 1'b0;
      bus.wreg     = 1'b0;
      bus.iord     = 1'b0;
      bus.regrt    = 1'b0;
      bus.m2reg    = 1'b0;
      bus.shift    = 1'b0;
      bus.alusrca  = 1'b0;
      bus.jal      = 1'b0;
      bus.sext     = 1'b1;
      bus.wepc     = 1'b0;
      bus.aluc     = 4'b0000;
      bus.alusrcb  = 2'd0;
      bus.pcsource = 3'd0;
      case (st)
         S_IF: begin
            bus.mem_req = 1'b1;
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'd1;
            bus.wpc     = bus.mem_ready;
            bus.wir     = bus.mem_ready;
         end
         S_ID: begin
            if (i_j | i_jal) begin
               bus.pcsource = 3'd3;
               bus.wpc      = 1'b1;
               bus.jal      = i_jal;
               bus.wreg     = i_jal;
            end else if (i_jr) begin
               bus.pcsource = 3'd2;
               bus.wpc      = 1'b1;
            end else if (legal) begin
               bus.alusrca = 1'b1;
               bus.alusrcb = 2'd3;
            end
         end
         S_EXE: begin
            bus.aluc = aluc_dec;
            if (i_beq | i_bne) begin
               bus.pcsource = 3'd1;
               bus.wpc      = (i_beq & bus.z) | (i_bne & ~bus.z);
            end else if (i_lw | i_sw) begin
               bus.alusrcb = 2'd2;
            end else begin
               bus.shift = i_shift;
               bus.sext  = ~i_zext_imm;
               if (i_imm)
                  bus.alusrcb = 2'd2;
            end
         end
         S_MEM: begin
            bus.mem_req = 1'b1;
            bus.iord    = 1'b1;
            bus.wmem    = i_sw;
         end
         S_WB: begin
            bus.wreg  = 1'b1;
            bus.m2reg = i_lw;
            bus.regrt = i_lw | i_imm;
         end
         S_TRAP: begin
            bus.pcsource = 3'd4;
            bus.wpc      = 1'b1;
            bus.wepc     = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.state = st;
   assign bus.cause = cause_q;
endmodule

// File: tb/tb_mccu_hs.sv
// tb/tb_mccu_hs.sv - self-checking bench for mccu_hs
`timescale 1ns/1ps
module tb_mccu_hs;
   logic clock = 1'b0;
   logic resetn;
   always #5 clock = ~clock;

   mccu_hs_if bus();
   mccu_hs_if bus_nt();

   mccu_hs #(.TRAP_EN(1), .WAIT_W(4), .MAX_WAIT(15)) dut (
      .clock(clock), .resetn(resetn), .bus(bus.master)
   );
   mccu_hs #(.TRAP_EN(0), .WAIT_W(4), .MAX_WAIT(15)) dut_nt (
      .clock(clock), .resetn(resetn), .bus(bus_nt.master)
   );

   localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EXE = 3'd2,
                          ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5;

   typedef enum int {K_ALU, K_SHIFT, K_IMM, K_LUI, K_LW, K_SW, K_BEQ, K_BNE,
                     K_J, K_JAL, K_JR, K_ILL} kind_e;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] func;
      kind_e      kind;
      logic [3:0] aluc;
      bit         zext;
   } vec_t;

   typedef struct packed {
      logic mem_req, wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext, wepc;
      logic [3:0] aluc;
      logic [1:0] alusrcb;
      logic [2:0] pcsource;
   } ctrl_t;

   typedef struct packed {
      logic [2:0] st;
      logic       rdy;
      logic       fixed;
      logic [1:0] set_cause;
   } phase_t;

   localparam int N_VEC = 22;
   localparam int I_ADD = 0, I_BEQ = 16, I_BNE = 17, I_LW = 14, I_SW = 15, I_ILL = 20;

   vec_t       tab [N_VEC];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [1:0] exp_cause = 2'b00;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   function automatic ctrl_t dut_ctrl();
      ctrl_t c;
      c = '{bus.mem_req, bus.wpc, bus.wir, bus.wmem, bus.wreg, bus.iord, bus.regrt, bus.m2reg,
            bus.shift, bus.alusrca, bus.jal, bus.sext, bus.wepc, bus.aluc, bus.alusrcb, bus.pcsource};
      return c;
   endfunction

   // Control word an instruction class should produce in a given phase.
   function automatic ctrl_t model(input vec_t v, input logic [2:0] st, input logic rdy, input logic zv);
      ctrl_t c;
      c = '0;
      c.sext = 1'b1;
      case (st)
         ST_IF: begin
            c.mem_req = 1'b1; c.alusrca = 1'b1; c.alusrcb = 2'd1;
            c.wpc = rdy; c.wir = rdy;
         end
         ST_ID: case (v.kind)
            K_J:   begin c.pcsource = 3'd3; c.wpc = 1'b1; end
            K_JAL: begin c.pcsource = 3'd3; c.wpc = 1'b1; c.jal = 1'b1; c.wreg = 1'b1; end
            K_JR:  begin c.pcsource = 3'd2; c.wpc = 1'b1; end
            K_ILL: ;
            default: begin c.alusrca = 1'b1; c.alusrcb = 2'd3; end
         endcase
         ST_EXE: begin
            c.aluc = v.aluc;
            case (v.kind)
               K_BEQ: begin c.pcsource = 3'd1; c.wpc = zv; end
               K_BNE: begin c.pcsource = 3'd1; c.wpc = !zv; end
               K_LW, K_SW: c.alusrcb = 2'd2;
               K_SHIFT: c.shift = 1'b1;
               K_IMM, K_LUI: begin c.alusrcb = 2'd2; c.sext = !v.zext; end
               default: ;
            endcase
         end
         ST_MEM: begin
            c.mem_req = 1'b1; c.iord = 1'b1; c.wmem = (v.kind == K_SW);
         end
         ST_WB: begin
            c.wreg  = 1'b1;
            c.m2reg = (v.kind == K_LW);
            c.regrt = (v.kind == K_LW) || (v.kind == K_IMM) || (v.kind == K_LUI);
         end
         ST_TRAP: begin
            c.pcsource = 3'd4; c.wpc = 1'b1; c.wepc = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic phase_t ph(input logic [2:0] st, input logic rdy, input logic fixed, input logic [1:0] sc);
      phase_t p;
      p.st = st; p.rdy = rdy; p.fixed = fixed; p.set_cause = sc;
      return p;
   endfunction

   // Waits of 16 or more mean the watchdog fires on the 16th idle cycle.
   task automatic add_access(inout phase_t q[$], input logic [2:0] st, input int w);
      for (int i = 0; i < w && i < 16; i++)
         q.push_back(ph(st, 1'b0, 1'b1, (i == 15) ? 2'd2 : 2'd0));
      if (w >= 16)
         q.push_back(ph(ST_TRAP, 1'b0, 1'b0, 2'd0));
      else
         q.push_back(ph(st, 1'b1, 1'b1, 2'd0));
   endtask

   task automatic run_instr(input int idx, input int if_w, input int mem_w, input logic zv, input bit rnd);
      phase_t q[$];
      vec_t   v;
      v = tab[idx];
      add_access(q, ST_IF, if_w);
      if (if_w < 16) begin
         q.push_back(ph(ST_ID, 1'b0, 1'b0, (v.kind == K_ILL) ? 2'd1 : 2'd0));
         case (v.kind)
            K_ILL: q.push_back(ph(ST_TRAP, 1'b0, 1'b0, 2'd0));
            K_J, K_JAL, K_JR: ;
            K_BEQ, K_BNE: q.push_back(ph(ST_EXE, 1'b0, 1'b0, 2'd0));
            K_LW, K_SW: begin
               q.push_back(ph(ST_EXE, 1'b0, 1'b0, 2'd0));
               add_access(q, ST_MEM, mem_w);
               if (mem_w < 16 && v.kind == K_LW)
                  q.push_back(ph(ST_WB, 1'b0, 1'b0, 2'd0));
            end
            default: begin
               q.push_back(ph(ST_EXE, 1'b0, 1'b0, 2'd0));
               q.push_back(ph(ST_WB, 1'b0, 1'b0, 2'd0));
            end
         endcase
      end
      bus.op = v.op;
      bus.func = v.func;
      bus.z = zv;
      foreach (q[i]) begin
         bus.mem_ready = q[i].fixed ? q[i].rdy : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         @(negedge clock);
         chk($sformatf("%s_w%0d_%0d_c%0d_state", v.name, if_w, mem_w, i), 32'(bus.state), 32'(q[i].st));
         chk($sformatf("%s_w%0d_%0d_c%0d_ctrl", v.name, if_w, mem_w, i), 32'(dut_ctrl()),
             32'(model(v, q[i].st, q[i].rdy, zv)));
         chk($sformatf("%s_c%0d_cause", v.name, i), 32'(bus.cause), 32'(exp_cause));
         @(posedge clock);
         #1;
         if (q[i].set_cause != 2'd0)
            exp_cause = q[i].set_cause;
      end
      chk($sformatf("%s_return_if", v.name), 32'(bus.state), 32'(ST_IF));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      tab[0]  = '{"add",  6'h00, 6'h20, K_ALU,   4'b0000, 1'b0};
      tab[1]  = '{"sub",  6'h00, 6'h22, K_ALU,   4'b0100, 1'b0};
      tab[2]  = '{"and",  6'h00, 6'h24, K_ALU,   4'b0001, 1'b0};
      tab[3]  = '{"or",   6'h00, 6'h25, K_ALU,   4'b0101, 1'b0};
      tab[4]  = '{"xor",  6'h00, 6'h26, K_ALU,   4'b0010, 1'b0};
      tab[5]  = '{"sll",  6'h00, 6'h00, K_SHIFT, 4'b0011, 1'b0};
      tab[6]  = '{"srl",  6'h00, 6'h02, K_SHIFT, 4'b0111, 1'b0};
      tab[7]  = '{"sra",  6'h00, 6'h03, K_SHIFT, 4'b1111, 1'b0};
      tab[8]  = '{"jr",   6'h00, 6'h08, K_JR,    4'b0000, 1'b0};
      tab[9]  = '{"addi", 6'h08, 6'h15, K_IMM,   4'b0000, 1'b0};
      tab[10] = '{"andi", 6'h0C, 6'h15, K_IMM,   4'b0001, 1'b1};
      tab[11] = '{"ori",  6'h0D, 6'h15, K_IMM,   4'b0101, 1'b1};
      tab[12] = '{"xori", 6'h0E, 6'h15, K_IMM,   4'b0010, 1'b1};
      tab[13] = '{"lui",  6'h0F, 6'h15, K_LUI,   4'b0110, 1'b0};
      tab[14] = '{"lw",   6'h23, 6'h15, K_LW,    4'b0000, 1'b0};
      tab[15] = '{"sw",   6'h2B, 6'h15, K_SW,    4'b0000, 1'b0};
      tab[16] = '{"beq",  6'h04, 6'h15, K_BEQ,   4'b0100, 1'b0};
      tab[17] = '{"bne",  6'h05, 6'h15, K_BNE,   4'b0100, 1'b0};
      tab[18] = '{"j",    6'h02, 6'h15, K_J,     4'b0000, 1'b0};
      tab[19] = '{"jal",  6'h03, 6'h15, K_JAL,   4'b0000, 1'b0};
      tab[20] = '{"ill3f",6'h3F, 6'h00, K_ILL,   4'b0000, 1'b0};
      tab[21] = '{"illfn",6'h00, 6'h01, K_ILL,   4'b0000, 1'b0};

      resetn = 1'b0;
      bus.op = '0; bus.func = '0; bus.z = 1'b0; bus.mem_ready = 1'b0;
      bus_nt.op = '0; bus_nt.func = '0; bus_nt.z = 1'b0; bus_nt.mem_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_state", 32'(bus.state), 32'(ST_IF));
      chk("reset_cause", 32'(bus.cause), 32'd0);
      chk("reset_wmem", 32'(bus.wmem), 32'd0);
      chk("reset_nt_state", 32'(bus_nt.state), 32'(ST_IF));
      resetn = 1'b1;

      for (int i = 0; i < N_VEC; i++)
         run_instr(i, 0, 0, 1'b0, 1'b0);

      run_instr(I_BEQ, 0, 0, 1'b1, 1'b0);
      run_instr(I_BNE, 0, 0, 1'b1, 1'b0);
      run_instr(I_LW, 3, 2, 1'b0, 1'b0);
      run_instr(I_ADD, 16, 0, 1'b0, 1'b0);
      run_instr(I_ADD, 15, 0, 1'b0, 1'b0);
      run_instr(I_SW, 0, 16, 1'b0, 1'b0);
      run_instr(I_LW, 0, 15, 1'b0, 1'b0);
      run_instr(I_ILL, 0, 0, 1'b0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         int idx;
         int iw;
         int mw;
         idx = $urandom_range(0, N_VEC - 1);
         iw = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 3);
         mw = ($urandom_range(0, 5) == 0) ? 16 : $urandom_range(0, 3);
         run_instr(idx, iw, mw, 1'($urandom_range(0, 1)), 1'b1);
      end

      // Abort a stalled store with reset and confirm a clean restart.
      run_instr(I_ILL, 0, 0, 1'b0, 1'b0);
      bus.op = 6'h2B; bus.func = 6'h00; bus.mem_ready = 1'b1;
      @(posedge clock); #1;
      bus.mem_ready = 1'b0;
      repeat (3) begin
         @(posedge clock); #1;
      end
      chk("sw_stall_state", 32'(bus.state), 32'(ST_MEM));
      chk("sw_stall_wmem", 32'(bus.wmem), 32'd1);
      chk("sw_stall_cause", 32'(bus.cause), 32'd1);
      resetn = 1'b0;
      #1;
      chk("sw_reset_state", 32'(bus.state), 32'(ST_IF));
      chk("sw_reset_wmem", 32'(bus.wmem), 32'd0);
      chk("sw_reset_cause", 32'(bus.cause), 32'd0);
      @(posedge clock); #1;
      resetn = 1'b1;
      exp_cause = 2'b00;
      run_instr(I_ADD, 0, 0, 1'b0, 1'b0);

      // Trap-disabled unit: no watchdog, illegal opcodes fall through as NOPs.
      repeat (20) begin
         @(posedge clock); #1;
      end
      chk("nt_no_timeout_state", 32'(bus_nt.state), 32'(ST_IF));
      chk("nt_no_timeout_req", 32'(bus_nt.mem_req), 32'd1);
      bus_nt.op = 6'h3F; bus_nt.mem_ready = 1'b1;
      @(posedge clock); #1;
      bus_nt.mem_ready = 1'b0;
      chk("nt_ill_id_state", 32'(bus_nt.state), 32'(ST_ID));
      chk("nt_ill_id_writes", 32'({bus_nt.wpc, bus_nt.wir, bus_nt.wmem, bus_nt.wreg, bus_nt.wepc}), 32'd0);
      @(posedge clock); #1;
      chk("nt_ill_back_if", 32'(bus_nt.state), 32'(ST_IF));
      chk("nt_ill_cause", 32'(bus_nt.cause), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mccu_hs.md
Name: mccu_hs

Overview:
- Parametrised successor to the multicycle CPU control unit.
- Adds a memory request/ready handshake with wait states to the IF and MEM states.
- Adds a memory-wait watchdog counter, and an illegal-instruction/timeout trap state that redirects the PC to a trap vector and writes EPC.
- Sits between the IR decode fields and the multicycle datapath (PC, IR, regfile, ALU, memory mux).

Parameters:
- TRAP_EN, 1: 1 enables the TRAP state; 0 makes illegal instructions behave as NOPs and disables the timeout.
- WAIT_W, 4: width of the wait-state counter.
- MAX_WAIT, 15: wait cycles allowed before a timeout trap; 0 disables the timeout; must be < 2^WAIT_W.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- op  in  6  IR[31:26]
- func  in  6  IR[5:0]
- z  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, alusrca, jal, sext  out  1 each  datapath controls (same meanings as the current control unit)
- aluc  out  4  ALU op: add 0000, and 0001, xor 0010, sll 0011, sub 0100, or 0101, lui 0110, srl 0111, sra 1111
- alusrcb  out  2  0 regB, 1 const 4, 2 imm, 3 branch offset
- pcsource  out  3  0 ALU, 1 branch, 2 jr, 3 jump, 4 trap vector
- wepc  out  1  EPC write enable
- cause  out  2  last trap cause: 00 none, 01 illegal, 10 timeout
- state  out  3  current FSM state

Behaviour:
- Supported ISA: MIPS-I encodings of add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal. Anything else is illegal.
- Registered: state, wait counter (WAIT_W bits), cause. All other outputs are combinational from state, decode, z and mem_ready.
- Output defaults: all 1-bit controls 0 except sext=1; aluc=0000; alusrcb=0; pcsource=0; mem_req=0. No X outputs.
- State encodings: IF=000, ID=001, EXE=010, MEM=011, WB=100, TRAP=101. Codes 110 and 111 go to IF.
- Reset (async): state=IF, counter=0, cause=00. Reset asserted mid-wait aborts the access; after release, mem_req reasserts in IF.
- IF:
  - Drives mem_req=1, alusrca=1, alusrcb=1.
  - If mem_ready: wpc=1, wir=1, next ID.
  - Otherwise, stay in IF and increment the counter.
- ID:
  - j: pcsource=3, wpc=1, next IF.
  - jal: as j, plus jal=1, wreg=1.
  - jr: pcsource=2, wpc=1, next IF.
  - Illegal instruction: next TRAP with cause<=01 if TRAP_EN; else next IF with no writes.
  - Otherwise: alusrca=1, alusrcb=3, aluc=add, next EXE.
- EXE:
  - aluc is decoded per the table above (addi/lw/sw/beq/bne use add/sub as in the current unit; andi/ori/xori use and/or/xor).
  - beq/bne: pcsource=1, wpc=(beq&z)|(bne&~z), next IF.
  - lw/sw: alusrcb=2, next MEM.
  - Otherwise: shift=1 for sll/srl/sra; alusrcb=2 for immediate ops; sext=0 for andi/ori/xori; next WB.
- MEM:
  - Drives mem_req=1, iord=1; wmem=1 for sw throughout MEM.
  - On mem_ready: lw goes to WB, sw goes to IF. Otherwise stay in MEM and increment the counter.
- Timeout:
  - Applies in IF or MEM.
  - Condition: TRAP_EN=1, MAX_WAIT≠0, counter==MAX_WAIT, and mem_ready=0.
  - Result: next TRAP, cause<=10, mem_req still driven that cycle.
  - mem_ready=1 on the same cycle wins; no trap.
- Counter: cleared on every state transition; saturates at 2^WAIT_W-1.
- WB:
  - wreg=1.
  - m2reg=1 for lw.
  - regrt=1 for lw and all I-type ALU ops.
  - Next IF.
- TRAP:
  - pcsource=4, wpc=1, wepc=1 (EPC captures PC, already PC+4), next IF.
  - cause holds until the next trap or reset.
- Cycle counts with zero wait: j/jal/jr 2, beq/bne 3, ALU ops 4, sw 4, lw 5, illegal 3. Each wait cycle adds 1.

Test Plan:
- Reset, then add with mem_ready tied high -> states IF,ID,EXE,WB; WB drives wreg=1, regrt=0, aluc=0000; total 4 cycles.
- lw with mem_ready low for 3 cycles in IF and 2 in MEM -> mem_req held, wpc/wir pulse only in the ready cycle; completes in 10 cycles with m2reg=1, regrt=1.
- beq with z=0 then z=1 -> EXE wpc=0 then wpc=1, pcsource=1; both return to IF.
- op=6'h3F with TRAP_EN=1 -> ID→TRAP; TRAP drives pcsource=4, wpc=1, wepc=1; cause=01. With TRAP_EN=0 -> ID→IF, no writes.
- mem_ready held low in IF with MAX_WAIT=15 -> 16th IF cycle goes to TRAP, cause=10. Raising mem_ready on that same cycle -> no trap, next ID.
- resetn pulsed low during a MEM wait for sw -> state=IF and wmem=0 immediately; cause=00; normal fetch resumes.
